// File: rtl/xnor_match_acc_pkg.sv
// Shared types for the XNOR match accumulator: the FSM state encoding,
// the registered window result, and the count-width helper.
package xnor_match_pkg;

   // Widest count ever needed: WIN tops out at 255, so 8 bits are enough.
   localparam int RES_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [RES_CNT_W-1:0] count;
      logic                 hit;
      logic                 all;
   } res_t;

   function automatic int cnt_width(input int win);
      return $clog2(win + 1);
   endfunction

endpackage

// File: rtl/xnor_match_acc_if.sv
// Beat input and window-result handshake bundle for xnor_match_acc.
// master = beat producer / result consumer, slave = accumulator.
interface xnor_match_acc_if #(
   parameter int WIN = 8
);
   localparam int CNT_W = xnor_match_pkg::cnt_width(WIN);

   logic             in_valid;
   logic             in_match;
   logic             in_ready;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_count;
   logic             res_hit;
   logic             res_all;

   modport master (
      output in_valid, in_match, res_ready,
      input  in_ready, res_valid, res_count, res_hit, res_all
   );

   modport slave (
      input  in_valid, in_match, res_ready,
      output in_ready, res_valid, res_count, res_hit, res_all
   );

endinterface

// File: rtl/xnor_match_acc.sv
// Windowed XNOR match accumulator. Counts matching beats over WIN accepted
// beats, then presents count / hit / all-match until the consumer takes it.
// Optional macro XNOR_MATCH_ACC_ABORT_EN adds in_abort, which drops a
// partial window.
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | no beats taken in the current window
// ST_ACC  | 1..WIN-1 beats taken, accumulating
// ST_HOLD | window complete, result presented
module xnor_match_acc
   import xnor_match_pkg::*;
#(
   parameter int WIN    = 8,
   parameter int THRESH = 6
) (
   input  logic clk,
   input  logic rst,
`ifdef XNOR_MATCH_ACC_ABORT_EN
   input  logic in_abort,
`endif
   xnor_match_acc_if.slave bus
);

   localparam int CNT_W = cnt_width(WIN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   res_t             res_q, res_d;

   logic             accept;
   logic [CNT_W-1:0] sum;
   logic             unused_res_hi;

   assign bus.in_ready  = (state_q != ST_HOLD);
   assign bus.res_valid = (state_q == ST_HOLD);
   assign bus.res_count = res_q.count[CNT_W-1:0];
   assign bus.res_hit   = res_q.hit;
   assign bus.res_all   = res_q.all;

   assign accept        = bus.in_valid && bus.in_ready;
   assign sum           = cnt_q + CNT_W'(bus.in_match);
   // Upper result bits are always zero for small WIN; fold them so they count as read.
   assign unused_res_hi = ^res_q.count;

   // Next-state, window counters and result capture.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d   = CNT_W'(1);
               cnt_d   = CNT_W'(bus.in_match);
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  res_d.count = RES_CNT_W'(sum);
                  res_d.hit   = (sum >= CNT_W'(THRESH));
                  res_d.all   = (sum == CNT_W'(WIN));
                  idx_d       = '0;
                  cnt_d       = '0;
                  state_d     = ST_HOLD;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
                  cnt_d = sum;
               end
            end
         end
         ST_HOLD: begin
            if (bus.res_ready) begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
`ifdef XNOR_MATCH_ACC_ABORT_EN
      // Abort wins over a same-cycle beat, including a window-closing one.
      if (in_abort && (state_q != ST_HOLD)) begin
         idx_d   = '0;
         cnt_d   = '0;
         res_d   = res_q;
         state_d = ST_IDLE;
      end
`endif
   end

   // State, counters and result register; async reset drops any partial window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

`ifndef SYNTHESIS
   a_match_known: assert property (@(posedge clk) disable iff (rst)
      bus.in_valid |-> !$isunknown(bus.in_match));

   a_res_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.res_valid && !bus.res_ready) |=>
         (bus.res_valid && $stable(bus.res_count) && $stable(bus.res_hit) && $stable(bus.res_all)));

   a_ready_state: assert property (@(posedge clk) disable iff (rst)
      bus.in_ready == (state_q != ST_HOLD));
`endif

endmodule

// File: tb/tb_xnor_match_acc.sv
// Directed bench for xnor_match_acc with WIN=8, THRESH=6.
module tb_xnor_match_acc;

   localparam int WIN    = 8;
   localparam int THRESH = 6;

   logic clk = 1'b0;
   logic rst;
`ifdef XNOR_MATCH_ACC_ABORT_EN
   logic in_abort;
`endif

   int errors = 0;
   int checks = 0;

   xnor_match_acc_if #(.WIN(WIN)) bus ();

   xnor_match_acc #(.WIN(WIN), .THRESH(THRESH)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef XNOR_MATCH_ACC_ABORT_EN
      .in_abort (in_abort),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic m);
      bus.in_valid = 1'b1;
      bus.in_match = m;
      step();
      bus.in_valid = 1'b0;
      bus.in_match = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_match = 1'b1;
      bus.res_ready = 1'b1;
      #2;
      step();
      step();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd0) begin errors++; $display("FAIL reset_res_count got=%0d exp=0", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b0) begin errors++; $display("FAIL reset_res_hit got=%b exp=0", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b0) begin errors++; $display("FAIL reset_res_all got=%b exp=0", bus.res_all); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      bus.in_valid = 1'b0;
      bus.in_match = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_all_ones();
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ones_in_ready beat=%0d got=%b exp=1", i, bus.in_ready); end
         send_beat(1'b1);
         if (i < 7) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid beat=%0d got=%b exp=0", i, bus.res_valid); end
         end
      end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL ones_res_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd8) begin errors++; $display("FAIL ones_res_count got=%0d exp=8", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b1) begin errors++; $display("FAIL ones_res_hit got=%b exp=1", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b1) begin errors++; $display("FAIL ones_res_all got=%b exp=1", bus.res_all); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ones_hold_ready got=%b exp=0", bus.in_ready); end
      step();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL ones_consumed got=%b exp=0", bus.res_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ones_ready_back got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat;
      pat = 8'b1110_1101;  // beats in order: 1,0,1,1,0,1,1,1
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_beat(pat[i]);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL b2b_res_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd6) begin errors++; $display("FAIL b2b_res_count got=%0d exp=6", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b1) begin errors++; $display("FAIL b2b_res_hit got=%b exp=1", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b0) begin errors++; $display("FAIL b2b_res_all got=%b exp=0", bus.res_all); end
      step();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed got=%b exp=0", bus.res_valid); end
   endtask

   task automatic test_gaps();
      int gap [8];
      gap = '{1, 2, 3, 1, 2, 3, 1, 2};
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         repeat (gap[i]) step();
         send_beat(1'b0);
         if (i == 6) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got=%b exp=0", bus.res_valid); end
         end
      end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL gaps_res_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd0) begin errors++; $display("FAIL gaps_res_count got=%0d exp=0", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b0) begin errors++; $display("FAIL gaps_res_hit got=%b exp=0", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b0) begin errors++; $display("FAIL gaps_res_all got=%b exp=0", bus.res_all); end
      step();
   endtask

   task automatic test_backpressure();
      bus.res_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_beat(1'b1);
      bus.in_valid = 1'b1;
      bus.in_match = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid cyc=%0d got=%b exp=1", i, bus.res_valid); end
         checks++; if (bus.res_count !== 4'd8) begin errors++; $display("FAIL bp_res_count cyc=%0d got=%0d exp=8", i, bus.res_count); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      end
      // Consume with a beat still offered: that beat must fall in the bubble.
      bus.res_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_match = 1'b0;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got=%b exp=0", bus.res_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); end
      for (int i = 0; i < 8; i++) send_beat(i == 7);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd1) begin errors++; $display("FAIL bp_next_count got=%0d exp=1", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b0) begin errors++; $display("FAIL bp_next_hit got=%b exp=0", bus.res_hit); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [7:0] pat;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(1'b1);
      rst = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstw_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstw_res_valid got=%b exp=0", bus.res_valid); end
      step();
      rst = 1'b0;
      // Partial window must be gone: a full 8 beats are needed again.
      bus.res_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_beat(1'b1);
         if (i == 6) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstw_leftover got=%b exp=0", bus.res_valid); end
         end
      end
      checks++; if (bus.res_count !== 4'd8) begin errors++; $display("FAIL rstw_count got=%0d exp=8", bus.res_count); end
      rst = 1'b1;
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rsth_res_valid got=%b exp=0", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd0) begin errors++; $display("FAIL rsth_res_count got=%0d exp=0", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b0) begin errors++; $display("FAIL rsth_res_hit got=%b exp=0", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b0) begin errors++; $display("FAIL rsth_res_all got=%b exp=0", bus.res_all); end
      bus.in_valid = 1'b1;
      bus.in_match = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_match = 1'b0;
      rst = 1'b0;
      bus.res_ready = 1'b1;
      pat = 8'b0101_0101;  // beats in order: 1,0,1,0,1,0,1,0
      for (int i = 0; i < 8; i++) send_beat(pat[i]);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL alt_res_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd4) begin errors++; $display("FAIL alt_res_count got=%0d exp=4", bus.res_count); end
      checks++; if (bus.res_hit !== 1'b0) begin errors++; $display("FAIL alt_res_hit got=%b exp=0", bus.res_hit); end
      checks++; if (bus.res_all !== 1'b0) begin errors++; $display("FAIL alt_res_all got=%b exp=0", bus.res_all); end
      step();
   endtask

`ifdef XNOR_MATCH_ACC_ABORT_EN
   task automatic test_abort();
      bus.res_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_beat(1'b1);
      in_abort = 1'b1;
      send_beat(1'b1);
      in_abort = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_beat(1'b1);
         if (i == 6) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL abort_early_valid got=%b exp=0", bus.res_valid); end
         end
      end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL abort_res_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd8) begin errors++; $display("FAIL abort_res_count got=%0d exp=8", bus.res_count); end
      bus.res_ready = 1'b0;
      in_abort = 1'b1;
      step();
      in_abort = 1'b0;
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL abort_hold_valid got=%b exp=1", bus.res_valid); end
      checks++; if (bus.res_count !== 4'd8) begin errors++; $display("FAIL abort_hold_count got=%0d exp=8", bus.res_count); end
      bus.res_ready = 1'b1;
      step();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL abort_consumed got=%b exp=0", bus.res_valid); end
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_match  = 1'b0;
      bus.res_ready = 1'b0;
`ifdef XNOR_MATCH_ACC_ABORT_EN
      in_abort = 1'b0;
`endif
      test_reset();
      test_all_ones();
      test_back_to_back();
      test_gaps();
      test_backpressure();
      test_reset_mid();
`ifdef XNOR_MATCH_ACC_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
